// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: drains a FIFO read port with 1-cycle read latency into a
// valid/ready stream. A 2-entry skid buffer plus one in-flight read keeps
// full throughput while never over-reading the FIFO.
module fifo_rd_stream #(
    parameter int unsigned DW = 16,
    parameter int unsigned CW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          fifo_empty,
    output logic          fifo_rd,
    input  logic [DW-1:0] fifo_dout,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [CW-1:0] xfer_cnt
);

    logic [DW-1:0] mem_q [2];
    logic          head_q;
    logic [1:0]    occ_q;
    logic          pend_q;
    logic [CW-1:0] cnt_q;

    logic          pop;
    logic          push;
    logic [2:0]    credit;
    logic          wr_idx;

    assign out_valid = (occ_q != 2'd0);
    assign out_data  = mem_q[head_q];
    assign xfer_cnt  = cnt_q;

    // Read credit: free slots once this cycle's pop and the in-flight word are
    // accounted for. occ + pend never exceeds 2, so credit never underflows.
    always_comb begin
        pop     = out_valid & out_ready;
        push    = pend_q;
        credit  = 3'd2 - {1'b0, occ_q} - {2'b00, pend_q} + {2'b00, pop};
        fifo_rd = ~rst & ~fifo_empty & (credit != 3'd0);
        // Tail slot: head + occ (mod 2); a push only happens with occ <= 1.
        wr_idx  = head_q ^ occ_q[0];
    end

    // Buffer, pending flag and transfer counter; reset discards everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            head_q   <= 1'b0;
            occ_q    <= 2'd0;
            pend_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            pend_q <= fifo_rd;
            if (push) begin
                mem_q[wr_idx] <= fifo_dout;
            end
            if (pop) begin
                head_q <= ~head_q;
                cnt_q  <= cnt_q + CW'(1);
            end
            occ_q <= occ_q + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: a queue-based FIFO model feeds the DUT, and a
// scoreboard of read-but-not-yet-delivered words predicts the stream side.
module tb_fifo_rd_stream;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          fifo_empty;
    logic          fifo_rd;
    logic          fifo_rd4;
    logic [DW-1:0] fifo_dout;
    logic          out_valid;
    logic          out_valid4;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [DW-1:0] out_data4;
    logic [31:0]   xfer_cnt;
    logic [3:0]    xfer_cnt4;

    always #5 clk = ~clk;

    fifo_rd_stream #(.DW(DW), .CW(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_rd    (fifo_rd),
        .fifo_dout  (fifo_dout),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .xfer_cnt   (xfer_cnt)
    );

    fifo_rd_stream #(.DW(DW), .CW(4)) dut4 (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_rd    (fifo_rd4),
        .fifo_dout  (fifo_dout),
        .out_valid  (out_valid4),
        .out_ready  (out_ready),
        .out_data   (out_data4),
        .xfer_cnt   (xfer_cnt4)
    );

    typedef struct {
        logic [DW-1:0] data;
        int            stamp;  // edge count at which the word was read
    } sb_t;

    typedef struct {
        logic          r;
        logic          g;
        logic          rdy;
        logic          e_rd;
        logic          e_valid;
        logic          chk_data;
        logic [DW-1:0] e_data;
        logic [31:0]   e_cnt;
    } vec_t;

    logic [DW-1:0] fq[$];
    sb_t           sb[$];
    int            edges;
    int            vectors;
    int            miscompares;
    logic [31:0]   cnt_m;

    logic          a_rd;
    logic          a_valid;
    logic [DW-1:0] a_data;
    logic [31:0]   a_cnt;
    logic [3:0]    a_cnt4;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive at negedge, compare against the model, then
    // advance the FIFO model and scoreboard after the rising edge.
    task automatic cycle(input logic r, input logic g, input logic rdy, input bit chk);
        logic e_valid;
        logic e_pop;
        logic e_rd;
        sb_t  t;
        @(negedge clk);
        rst        = r;
        out_ready  = rdy;
        fifo_empty = g || (fq.size() == 0);
        #1;
        // A word is visible once the edge after its read has captured it.
        e_valid = (sb.size() > 0) && (edges >= sb[0].stamp + 1);
        e_pop   = e_valid && rdy;
        // At most two words may be read and not yet delivered.
        e_rd    = !r && !fifo_empty && ((sb.size() - (e_pop ? 1 : 0)) < 2);
        a_rd    = fifo_rd;
        a_valid = out_valid;
        a_data  = out_data;
        a_cnt   = xfer_cnt;
        a_cnt4  = xfer_cnt4;
        if (chk) begin
            check("fifo_rd", {31'd0, a_rd}, {31'd0, e_rd});
            check("out_valid", {31'd0, a_valid}, {31'd0, e_valid});
            if (e_valid) check("out_data", {16'd0, a_data}, {16'd0, sb[0].data});
            check("xfer_cnt", a_cnt, cnt_m);
            check("xfer_cnt4", {28'd0, a_cnt4}, {28'd0, cnt_m[3:0]});
            check("rd_while_empty", {31'd0, a_rd & fifo_empty}, 32'd0);
        end
        @(posedge clk);
        #1;
        edges++;
        if (r) begin
            sb.delete();
            cnt_m = 0;
        end else begin
            if (e_pop) begin
                sb.delete(0);
                cnt_m = cnt_m + 1;
            end
            if (e_rd) begin
                t.data  = fq[0];
                t.stamp = edges;
                sb.push_back(t);
            end
        end
        if (a_rd && !fifo_empty && fq.size() > 0) fifo_dout = fq.pop_front();
        else fifo_dout = DW'($urandom);
    endtask

    vec_t          tbl[6];
    logic [DW-1:0] got[$];
    int            pulses;
    bit            found;

    initial begin
        rst         = 1'b1;
        out_ready   = 1'b0;
        fifo_empty  = 1'b1;
        fifo_dout   = '0;
        edges       = 0;
        vectors     = 0;
        miscompares = 0;
        cnt_m       = 0;

        // Reset with a non-empty FIFO, then a single word 0x00A5.
        fq.push_back(16'h00A5);
        cycle(1'b1, 1'b0, 1'b1, 1'b0);
        //         r     g     rdy   e_rd  e_val chkd  data      cnt
        tbl[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 32'd0};
        tbl[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 32'd0};
        tbl[2] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0000, 32'd0};
        tbl[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 32'd0};
        tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h00A5, 32'd0};
        tbl[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 32'd1};
        for (int i = 0; i < 6; i++) begin
            cycle(tbl[i].r, tbl[i].g, tbl[i].rdy, 1'b1);
            check("tbl_rd", {31'd0, a_rd}, {31'd0, tbl[i].e_rd});
            check("tbl_valid", {31'd0, a_valid}, {31'd0, tbl[i].e_valid});
            if (tbl[i].chk_data) check("tbl_data", {16'd0, a_data}, {16'd0, tbl[i].e_data});
            check("tbl_cnt", a_cnt, tbl[i].e_cnt);
        end

        // Streaming 0x0001..0x0010 at full rate.
        cycle(1'b1, 1'b0, 1'b1, 1'b1);
        for (int k = 1; k <= 16; k++) fq.push_back(DW'(k));
        for (int i = 0; i < 18; i++) begin
            cycle(1'b0, 1'b0, 1'b1, 1'b1);
            if (i >= 2) begin
                check("stream_valid", {31'd0, a_valid}, 32'd1);
                check("stream_data", {16'd0, a_data}, 32'(i - 1));
            end
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check("stream_cnt", a_cnt, 32'd16);

        // Backpressure: 4 words queued, downstream stalled.
        cycle(1'b1, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) fq.push_back(16'h0100 + DW'(k));
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b1);
            pulses += int'(a_rd);
            if (i >= 2) begin
                check("bp_hold_valid", {31'd0, a_valid}, 32'd1);
                check("bp_hold_data", {16'd0, a_data}, 32'h0100);
            end
        end
        check("bp_rd_pulses", pulses, 32'd2);
        got.delete();
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'b0, 1'b1, 1'b1);
            if (a_valid) got.push_back(a_data);
        end
        check("bp_count", got.size(), 32'd4);
        for (int k = 0; k < got.size(); k++) check("bp_order", {16'd0, got[k]}, 32'h0100 + k);

        // Counter wrap with a 4-bit counter: 17 transfers.
        cycle(1'b1, 1'b0, 1'b1, 1'b1);
        for (int k = 0; k < 17; k++) fq.push_back(16'h0300 + DW'(k));
        for (int i = 0; i < 21; i++) cycle(1'b0, 1'b0, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check("wrap_cnt4", {28'd0, a_cnt4}, 32'd1);
        check("wrap_cnt", a_cnt, 32'd17);

        // Reset mid-stream with buffered and in-flight words.
        cycle(1'b1, 1'b0, 1'b1, 1'b1);
        for (int k = 0; k < 8; k++) fq.push_back(16'h0200 + DW'(k));
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b1, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 1'b1);
        check("rst_rd", {31'd0, a_rd}, 32'd0);
        cycle(1'b0, 1'b0, 1'b1, 1'b1);
        check("post_rst_valid", {31'd0, a_valid}, 32'd0);
        found = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 1'b0, 1'b1, 1'b1);
            if (a_valid && !found) begin
                found = 1'b1;
                check("resume_data", {16'd0, a_data}, 32'h0204);
            end
        end
        check("resume_found", {31'd0, found}, 32'd1);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 2) == 0 && fq.size() < 8) fq.push_back(DW'($urandom));
            if ($urandom_range(0, 9) == 0 && fq.size() < 8) fq.push_back(DW'($urandom));
            cycle($urandom_range(0, 99) == 0, $urandom_range(0, 4) == 0,
                  $urandom_range(0, 9) < 7, 1'b1);
        end
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, 1'b1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
